// File: rtl/dmem_responder.sv
// MEM-stage data-access responder: serialises one load/store at a time onto a
// single-port synchronous word RAM, with read-modify-write for sub-word stores.
module dmem_responder #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    localparam int unsigned TOP_LSB = ADDR_W + 2;

    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_t;

    state_t      state;
    logic        we_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic        accept;
    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_ready_o = (state == IDLE);
    assign accept      = req_valid_i & req_ready_o;

    // Request legality: size code, natural alignment, and RAM range
    always_comb begin
        req_err = 1'b0;
        case (req_size_i)
            2'b01:   req_err = req_addr_i[0];
            2'b10:   req_err = (req_addr_i[1:0] != 2'b00);
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if ((req_addr_i >> TOP_LSB) != 32'd0) begin
            req_err = 1'b1;
        end
    end

    // Little-endian lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        byte_sel  = ram_rdata_i[{lane_q, 3'b000} +: 8];
        half_sel  = ram_rdata_i[{lane_q[1], 4'b0000} +: 16];
        load_data = ram_rdata_i;
        merged    = ram_rdata_i;
        case (size_q)
            2'b00: begin
                load_data = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_data = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
                merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
            end
            default: begin
                load_data = ram_rdata_i;
                merged    = ram_rdata_i;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= 16'd0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= 32'd0;
            ram_addr_o  <= '0;
            ram_we_o    <= 1'b0;
            ram_wdata_o <= 32'd0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we_i;
                        lane_q  <= req_addr_i[1:0];
                        wdata_q <= req_wdata_i[15:0];
                        size_q  <= req_size_i;
                        uns_q   <= req_unsigned_i;
                        if (req_err) begin
                            // Rejected without touching the RAM; stay ready
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= 32'd0;
                        end else begin
                            ram_addr_o <= req_addr_i[ADDR_W+1:2];
                            if (req_we_i && (req_size_i == 2'b10)) begin
                                ram_wdata_o <= req_wdata_i;
                                ram_we_o    <= 1'b1;
                                state       <= WR;
                            end else begin
                                ram_we_o <= 1'b0;
                                state    <= RD_ADDR;
                            end
                        end
                    end
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    if (we_q) begin
                        ram_wdata_o <= merged;
                        ram_we_o    <= 1'b1;
                        state       <= WR;
                    end else begin
                        rsp_rdata_o <= load_data;
                        rsp_valid_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                WR: begin
                    ram_we_o    <= 1'b0;
                    rsp_valid_o <= 1'b1;
                    rsp_rdata_o <= 32'd0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios, reset-abort cases
// and randomized traffic against a word-array reference memory.
module tb_dmem_responder;

    localparam int unsigned AW    = 10;
    localparam int unsigned WORDS = 1 << AW;

    logic          clk;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [31:0]   req_addr_i;
    logic [31:0]   req_wdata_i;
    logic [1:0]    req_size_i;
    logic          req_unsigned_i;
    logic          rsp_valid_o;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic [AW-1:0] ram_addr_o;
    logic          ram_we_o;
    logic [31:0]   ram_wdata_o;
    logic [31:0]   ram_rdata_i;

    dmem_responder #(.ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [WORDS];
    logic [31:0] ref_mem [WORDS];
    int          cyc = 0;
    int          wr_count = 0;
    int          total = 0;
    int          bad = 0;
    int          last_acc = -1;
    int          busy_until = -1;
    bit          started = 0;

    // Backing RAM: 1-cycle registered read, whole-word write
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ram_rdata_i <= mem[ram_addr_o];
        if (ram_we_o) begin
            mem[ram_addr_o] <= ram_wdata_o;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every response, tracks ready per cycle
    always @(negedge clk) begin
        if (started) begin
            exp_t e;
            chk("req_ready", 32'(req_ready_o),
                32'(!(cyc > last_acc && cyc <= busy_until)));
            if (rsp_valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
                    chk("rsp_rdata", rsp_rdata_o, e.rdata);
                    chk("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    // Reference behaviour from the request rules; updates ref_mem for stores
    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] size, input logic uns,
                                  output logic err, output logic [31:0] rdata, output int lat);
        int unsigned idx, sh, w, v, mask;
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)
              || (addr >= (32'd1 << (AW + 2)));
        rdata = 32'd0;
        if (err) begin
            lat = 1;
            return;
        end
        idx = (addr >> 2) % WORDS;
        sh  = 8 * (addr % 4);
        w   = ref_mem[idx];
        mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (!we) begin
            lat = 3;
            v = (w >> sh) & mask;
            if (!uns && size == 2'd0 && v >= 128)   v = v | 32'hFFFF_FF00;
            if (!uns && size == 2'd1 && v >= 32768) v = v | 32'hFFFF_0000;
            rdata = v;
        end else if (size == 2'd2) begin
            lat = 2;
            ref_mem[idx] = wdata;
        end else begin
            lat = 4;
            ref_mem[idx] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
        end
    endfunction

    // Present a request until accepted; returns accept cycle (-1 on timeout)
    task automatic present(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns, output int acc);
        int n = 0;
        req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
        req_size_i = size; req_unsigned_i = uns; req_valid_i = 1'b1;
        @(negedge clk);
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            chk("accept_timeout", 32'(req_ready_o), 32'd1);
            acc = -1;
        end else begin
            acc = cyc;
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input bit use_k,
                         input logic [31:0] k_rdata, input int gap);
        int acc, lat;
        exp_t e;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        present(we, addr, wdata, size, uns, acc);
        if (acc >= 0) begin
            model(we, addr, wdata, size, uns, e.err, e.rdata, lat);
            if (use_k) e.rdata = k_rdata;
            e.due = acc + lat;
            q.push_back(e);
            last_acc   = acc;
            busy_until = acc + lat - 1;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        chk({tag, "_outs"}, {rsp_valid_o, rsp_err_o, ram_we_o, 29'd0}, 32'd0);
        chk({tag, "_rdata"}, rsp_rdata_o, 32'd0);
        chk({tag, "_raddr"}, 32'(ram_addr_o), 32'd0);
        chk({tag, "_wdata"}, ram_wdata_o, 32'd0);
    endtask

    // Accept a request, then pulse reset d cycles into it; no response expected
    task automatic issue_rst(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input int d, input bit commits);
        int acc;
        present(we, addr, wdata, size, 1'b0, acc);
        last_acc   = acc;
        busy_until = acc + ((size == 2'd2) ? 1 : 3);
        repeat (d) begin
            @(posedge clk);
            #1;
        end
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        busy_until = -1;
        if (commits) ref_mem[(addr >> 2) % WORDS] = wdata;
        @(negedge clk);
        check_idle_zero("post_rst");
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w0, mism;
        for (int i = 0; i < int'(WORDS); i++) begin
            mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        rst_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 32'd0;
        req_wdata_i = 32'd0; req_size_i = 2'd0; req_unsigned_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rst_i = 1'b1;
        started = 1;
        @(posedge clk);
        #1;

        // Word store then load
        w0 = wr_count;
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b1, 32'd0, 0);
        issue(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 1'b1, 32'hDEAD_BEEF, 0);
        drain();
        chk("sw_write_count", 32'(wr_count - w0), 32'd1);
        chk("sw_ram_word4", mem[4], 32'hDEAD_BEEF);

        // Byte store via RMW, then reads of the merged word and lane
        issue(1'b1, 32'h12, 32'hFFFF_FF80, 2'd0, 1'b0, 1'b1, 32'd0, 1);
        issue(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 1'b1, 32'hDE80_BEEF, 0);
        issue(1'b0, 32'h12, 32'd0, 2'd0, 1'b0, 1'b1, 32'hFFFF_FF80, 0);
        issue(1'b0, 32'h12, 32'd0, 2'd0, 1'b1, 1'b1, 32'h0000_0080, 0);
        drain();

        // Error requests back to back: no RAM write, ready stays high
        w0 = wr_count;
        issue(1'b0, 32'h13, 32'd0, 2'd1, 1'b0, 1'b1, 32'd0, 0);
        issue(1'b0, 32'h10, 32'd0, 2'd3, 1'b0, 1'b1, 32'd0, 0);
        issue(1'b0, 32'h1000, 32'd0, 2'd2, 1'b0, 1'b1, 32'd0, 0);
        issue(1'b1, 32'h11, 32'h1234_5678, 2'd2, 1'b0, 1'b1, 32'd0, 0);
        drain();
        chk("err_write_count", 32'(wr_count - w0), 32'd0);

        // Back-to-back with valid held
        issue(1'b1, 32'h0, 32'h0000_8001, 2'd2, 1'b0, 1'b1, 32'd0, 0);
        issue(1'b0, 32'h0, 32'd0, 2'd1, 1'b0, 1'b1, 32'hFFFF_8001, 0);
        issue(1'b0, 32'h2, 32'd0, 2'd1, 1'b1, 1'b1, 32'h0000_0000, 0);
        drain();

        // Reset during RD_DATA of a half store: store is lost
        issue(1'b1, 32'h20, 32'h1122_3344, 2'd2, 1'b0, 1'b1, 32'd0, 0);
        drain();
        w0 = wr_count;
        issue_rst(1'b1, 32'h22, 32'h0000_ABCD, 2'd1, 1, 1'b0);
        chk("rst_rd_no_write", 32'(wr_count - w0), 32'd0);
        issue(1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 1'b1, 32'h1122_3344, 0);
        drain();

        // Reset during WR of a word store: that write still lands
        issue_rst(1'b1, 32'h24, 32'hCAFE_F00D, 2'd2, 0, 1'b1);
        chk("rst_wr_ram", mem[9], 32'hCAFE_F00D);
        issue(1'b0, 32'h24, 32'd0, 2'd2, 1'b0, 1'b1, 32'hCAFE_F00D, 0);
        drain();

        // Randomized traffic against the reference memory
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            if ($urandom_range(0, 15) == 0) a = $urandom | 32'h1000;
            else a = $urandom_range(0, 255);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            issue(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
                  1'b0, 32'd0, $urandom_range(0, 2));
        end
        drain();

        mism = 0;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (mem[i] !== ref_mem[i]) mism++;
        end
        chk("ram_contents", 32'(mism), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
